seq_fxp_divider: RTL and testbench
==================================

Name: seq_fxp_divider

Overview:
- Parametrised multi-cycle fixed-point divider co-processor; generalises the CPU's program-2 operation of a 16-bit integer divided by an 8-bit integer, giving a 24-bit quotient with 8 fraction bits.
- Restoring radix-2 algorithm, one quotient bit per clock.
- Selectable truncate or half-LSB-up rounding, divide-by-zero saturation, level start/ack handshake.
- Sits beside the CPU datapath as a DIV unit. The CPU latches operands at start and reads the result once ack is high.

Parameters:
- DW, 16, dividend width (unsigned integer).
- VW, 8, divisor width (unsigned integer).
- FW, 8, fraction bits in the quotient. QW = DW+FW is the result width.
- ROUND, 0, 0 = truncate; 1 = round half-LSB upward.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  DW  unsigned dividend; latched on the accepting edge.
- divisor  in  VW  unsigned divisor; latched on the accepting edge.
- busy  out  1  high in CALC and FIN.
- ack  out  1  level done flag; high in DONE.
- quotient  out  QW  result, Q(DW.FW) unsigned.
- dz  out  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, ack=0, quotient=0, dz=0; all internal registers cleared. Reset mid-operation abandons the division; no partial result is visible.
- Math: N = QW+ROUND iterations. Raw q = floor(dividend * 2^(FW+ROUND) / divisor), N bits.
  - ROUND=0: quotient = q.
  - ROUND=1: quotient = (q+1)>>1.
  - Overflow of that add saturates quotient to all ones; unreachable for divisor>=1 but must still be implemented.
- Datapath widths: partial remainder VW+1 bits; dividend shift register N bits (dividend<<(FW+ROUND)); quotient shift register N bits. Unsigned compare/subtract throughout.
- FSM states IDLE, CALC, FIN, DONE:
  - IDLE: start=1 latches operands.
    - divisor==0: next state DONE; quotient = all ones; dz=1. Latency 1 edge.
    - Otherwise: next state CALC; counter=N-1; remainder=0; dz=0.
  - CALC: each edge shifts the next dividend bit into the remainder. If remainder >= divisor, subtract and shift a 1 into q; else shift a 0. Leaves for FIN when counter==0. Exactly N edges in CALC.
  - FIN: one edge; applies rounding/saturation and registers quotient; next state DONE.
  - DONE: ack=1; quotient and dz held stable.
    - start=1: re-accept, same rules as IDLE; ack drops on that edge.
    - start=0: stay in DONE.
- Latency: for a nonzero divisor, ack rises N+2 edges after the accepting edge. With the defaults and ROUND=0 that is 26 edges.
- start during CALC or FIN is ignored; operand input changes after acceptance have no effect.
- start held high continuously: every arrival in DONE lasts exactly one cycle before re-acceptance. Back-to-back operation is legal.
- quotient is updated only on the FIN edge or the divide-by-zero edge. It keeps the previous value during CALC, and the bench checks this.

Decomposition:
- Package fxp_div_pkg holds:
  - the state enum type (IDLE, CALC, FIN, DONE);
  - localparam helpers for QW and N derived from DW, FW and ROUND;
  - the saturation constant macro/function (all ones of QW).
- One sub-module, div_step: purely combinational restoring step. Inputs are remainder (VW+1), next dividend bit and divisor. Outputs are next remainder and quotient bit. Instantiated once in seq_fxp_divider.

Test Plan (defaults DW=16, VW=8, FW=8):
- 90/5, ROUND=0 -> quotient=0x001200, dz=0, ack rises exactly 26 edges after the accepting edge; busy high for 25 cycles.
- 270/14, ROUND=0 -> 0x001349. 3/116, ROUND=0 -> 0x000006. 3/116 with ROUND=1 -> 0x000007 and latency 27 edges.
- divisor=0, dividend=1234 -> quotient=0xFFFFFF, dz=1, ack after 1 edge. A following 65535/1 -> 0xFFFF00 with dz cleared.
- Disturbance during CALC: start pulsed and operands changed to 7/3 mid-CALC of 90/5 -> still 0x001200. Reset asserted mid-CALC -> busy=0, ack=0, quotient=0 immediately (async); a new 90/5 afterwards completes correctly.
- start held high for three operations (90/5, 270/14, 3/116) -> each result is correct, ack drops for the N+1 cycles between results, and each result holds stable while ack=1.

Source files
------------

// File: rtl/seq_fxp_divider_pkg.sv
// Shared definitions for the sequential fixed-point divider.
//   state_e   : controller states
//   calc_qw   : result width from dividend and fraction widths
//   calc_n    : iteration count (one extra when rounding)
//   sat_ones  : all-ones pattern of a given width, for saturation
package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int calc_qw(input int dw, input int fw);
    return dw + fw;
  endfunction

  function automatic int calc_n(input int dw, input int fw, input int round);
    return dw + fw + round;
  endfunction

  // Widths up to 64 bits; callers slice the low bits they need.
  function automatic logic [63:0] sat_ones(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;
  localparam int DEF_FW = 8;
  localparam int DEF_QW = calc_qw(DEF_DW, DEF_FW);

endpackage

// File: rtl/seq_fxp_divider_if.sv
// CPU-side handshake and operand/result bundle for the divider.
//   master : drives start/dividend/divisor, observes busy/ack/quotient/dz
//   slave  : the divider side
interface seq_fxp_divider_if
  import fxp_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW,
  parameter int FW = DEF_FW
);
  localparam int QW = calc_qw(DW, FW);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          ack;
  logic [QW-1:0] quotient;
  logic          dz;

  modport master (
    output start, dividend, divisor,
    input  busy, ack, quotient, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, ack, quotient, dz
  );

endinterface

// File: rtl/seq_fxp_divider_div_step.sv
// One restoring-division step, purely combinational.
//   rem_in  : partial remainder (VW+1 bits)
//   bit_in  : next dividend bit shifted in
//   divisor : unsigned divisor
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this step
module div_step
  import fxp_div_pkg::*;
#(
  parameter int VW = DEF_VW
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic        ge;

  always_comb begin
    shifted = {rem_in[VW-1:0], bit_in};
    // A set top remainder bit means the true shifted value exceeds any divisor.
    ge      = rem_in[VW] | (shifted >= {1'b0, divisor});
    q_bit   = ge;
    rem_out = ge ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/seq_fxp_divider.sv
// Multi-cycle unsigned fixed-point divider, one quotient bit per clock.
// quotient = floor(dividend * 2^FW / divisor), optionally rounded half-up,
// saturated to all ones on divide-by-zero.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : start/dividend/divisor in; busy/ack/quotient/dz out
//
// state | meaning
// IDLE  | waiting for start after reset
// CALC  | shifting one dividend bit per edge through the restoring step
// FIN   | rounding/saturation, result registered
// DONE  | ack high, result held; start re-accepts
module seq_fxp_divider
  import fxp_div_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int VW    = DEF_VW,
  parameter int FW    = DEF_FW,
  parameter int ROUND = 0
) (
  input  logic              clk,
  input  logic              reset,
  seq_fxp_divider_if.slave  bus
);

  localparam int QW = calc_qw(DW, FW);
  localparam int N  = calc_n(DW, FW, ROUND);
  localparam int SH = FW + ROUND;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [63:0]   SAT_W    = sat_ones(QW);
  localparam logic [QW-1:0] SAT      = SAT_W[QW-1:0];
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   rem_q, rem_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  qsh_q, qsh_d;
  logic [VW-1:0] dvsr_q, dvsr_d;
  logic [QW-1:0] quotient_q, quotient_d;
  logic          dz_q, dz_d;

  logic [VW:0]   step_rem;
  logic          step_bit;
  logic [QW-1:0] fin_result;

  div_step #(.VW(VW)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[N-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  generate
    if (ROUND != 0) begin : g_round
      // (q + 1) >> 1 computed as (q >> 1) + q[0]; the carry out is the overflow.
      logic [QW:0] half_up;
      assign half_up    = {1'b0, qsh_q[N-1:1]} + {{QW{1'b0}}, qsh_q[0]};
      assign fin_result = half_up[QW] ? SAT : half_up[QW-1:0];
    end else begin : g_trunc
      assign fin_result = qsh_q[QW-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      qsh_q      <= '0;
      dvsr_q     <= '0;
      quotient_q <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      qsh_q      <= qsh_d;
      dvsr_q     <= dvsr_d;
      quotient_q <= quotient_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    qsh_d      = qsh_q;
    dvsr_d     = dvsr_q;
    quotient_d = quotient_q;
    dz_d       = dz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dvsr_d = bus.divisor;
          if (bus.divisor == '0) begin
            state_d    = DONE;
            quotient_d = SAT;
            dz_d       = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_INIT;
            rem_d   = '0;
            dvd_d   = N'(bus.dividend) << SH;
            qsh_d   = '0;
            dz_d    = 1'b0;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[N-2:0], 1'b0};
        qsh_d = {qsh_q[N-2:0], step_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIN;
      end
      FIN: begin
        quotient_d = fin_result;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == CALC) || (state_q == FIN);
  assign bus.ack      = (state_q == DONE);
  assign bus.quotient = quotient_q;
  assign bus.dz       = dz_q;

endmodule

// File: tb/tb_seq_fxp_divider.sv
module tb_seq_fxp_divider;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int FW = 8;
  localparam int QW = 24;
  localparam int N0 = 24;
  localparam int N1 = 25;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_fxp_divider_if #(.DW(DW), .VW(VW), .FW(FW)) if0 ();
  seq_fxp_divider_if #(.DW(DW), .VW(VW), .FW(FW)) if1 ();

  seq_fxp_divider #(.DW(DW), .VW(VW), .FW(FW), .ROUND(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  seq_fxp_divider #(.DW(DW), .VW(VW), .FW(FW), .ROUND(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference: floor(a * 2^(FW+r) / b), rounded half up when r=1, saturated.
  function automatic logic [QW-1:0] ref_q(input int r, input logic [15:0] a, input logic [7:0] b);
    longint q;
    if (b == 8'd0) return 24'hFFFFFF;
    q = (longint'(a) * (longint'(1) << (FW + r))) / longint'(b);
    if (r != 0) q = (q + 1) / 2;
    if (q > 64'sh0FFFFFF) q = 64'sh0FFFFFF;
    return q[QW-1:0];
  endfunction

  // Runs one operation; reports edge count (accepting edge = 1), busy cycles,
  // whether quotient stayed unchanged while busy, and timeout.
  task automatic do_op(input bit sel, input logic [15:0] a, input logic [7:0] b,
                       output int edges, output int busy_n, output bit held, output bit tmo);
    logic [QW-1:0] q0;
    logic          cb, ca;
    logic [QW-1:0] cq;
    @(negedge clk);
    q0 = sel ? if1.quotient : if0.quotient;
    if (sel) begin if1.start = 1'b1; if1.dividend = a; if1.divisor = b; end
    else     begin if0.start = 1'b1; if0.dividend = a; if0.divisor = b; end
    edges = 0; busy_n = 0; held = 1'b1; tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        if (sel) begin if1.start = 1'b0; if1.dividend = 16'($urandom); if1.divisor = 8'($urandom); end
        else     begin if0.start = 1'b0; if0.dividend = 16'($urandom); if0.divisor = 8'($urandom); end
      end
      edges++;
      cb = sel ? if1.busy : if0.busy;
      ca = sel ? if1.ack : if0.ack;
      cq = sel ? if1.quotient : if0.quotient;
      if (cb) begin
        busy_n++;
        if (cq !== q0) held = 1'b0;
      end
      if (ca) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if0.start = 1'b0; if0.dividend = '0; if0.divisor = '0;
    if1.start = 1'b0; if1.dividend = '0; if1.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (if0.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy0: got %b want 0", if0.busy); end
    vectors++; if (if0.ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack0: got %b want 0", if0.ack); end
    vectors++; if (if0.quotient !== 24'h0) begin miscompares++; $display("FAIL reset_q0: got %h want 000000", if0.quotient); end
    vectors++; if (if0.dz !== 1'b0) begin miscompares++; $display("FAIL reset_dz0: got %b want 0", if0.dz); end
    vectors++; if (if1.ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack1: got %b want 0", if1.ack); end
    vectors++; if (if1.quotient !== 24'h0) begin miscompares++; $display("FAIL reset_q1: got %h want 000000", if1.quotient); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int e, bn; bit h, t;
    logic [15:0] av [4] = '{16'd90, 16'd270, 16'd3, 16'd3};
    logic [7:0]  bv [4] = '{8'd5, 8'd14, 8'd116, 8'd116};
    logic [23:0] qv [4] = '{24'h001200, 24'h001349, 24'h000006, 24'h000007};
    bit          sv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      do_op(sv[k], av[k], bv[k], e, bn, h, t);
      vectors++; if (t) begin miscompares++; $display("FAIL dir%0d_timeout: no ack within 200 edges", k); end
      vectors++;
      if ((sv[k] ? if1.quotient : if0.quotient) !== qv[k]) begin
        miscompares++; $display("FAIL dir%0d_quot: got %h want %h", k, sv[k] ? if1.quotient : if0.quotient, qv[k]);
      end
      vectors++;
      if ((sv[k] ? if1.dz : if0.dz) !== 1'b0) begin miscompares++; $display("FAIL dir%0d_dz: got 1 want 0", k); end
      vectors++;
      if (e != (sv[k] ? N1 + 2 : N0 + 2)) begin miscompares++; $display("FAIL dir%0d_latency: got %0d want %0d", k, e, sv[k] ? N1 + 2 : N0 + 2); end
      vectors++;
      if (bn != (sv[k] ? N1 + 1 : N0 + 1)) begin miscompares++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", k, bn, sv[k] ? N1 + 1 : N0 + 1); end
      vectors++; if (!h) begin miscompares++; $display("FAIL dir%0d_hold_during_calc: got changed want held", k); end
    end
  endtask

  task automatic test_div_zero();
    int e, bn; bit h, t;
    do_op(1'b0, 16'd1234, 8'd0, e, bn, h, t);
    vectors++; if (t) begin miscompares++; $display("FAIL dz_timeout: no ack"); end
    vectors++; if (if0.quotient !== 24'hFFFFFF) begin miscompares++; $display("FAIL dz_quot: got %h want ffffff", if0.quotient); end
    vectors++; if (if0.dz !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b want 1", if0.dz); end
    vectors++; if (e != 1) begin miscompares++; $display("FAIL dz_latency: got %0d want 1", e); end
    do_op(1'b0, 16'd65535, 8'd1, e, bn, h, t);
    vectors++; if (if0.quotient !== 24'hFFFF00) begin miscompares++; $display("FAIL max_quot: got %h want ffff00", if0.quotient); end
    vectors++; if (if0.dz !== 1'b0) begin miscompares++; $display("FAIL max_dz_clear: got %b want 0", if0.dz); end
    vectors++; if (e != N0 + 2) begin miscompares++; $display("FAIL max_latency: got %0d want %0d", e, N0 + 2); end
  endtask

  task automatic test_disturb();
    int e, bn; bit h, t, seen;
    @(negedge clk);
    if0.start = 1'b1; if0.dividend = 16'd90; if0.divisor = 8'd5;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    if0.start = 1'b1; if0.dividend = 16'd7; if0.divisor = 8'd3;
    @(negedge clk);
    if0.start = 1'b0;
    vectors++; if (if0.busy !== 1'b1) begin miscompares++; $display("FAIL disturb_busy: got %b want 1", if0.busy); end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (if0.ack) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL disturb_timeout: no ack"); end
    vectors++; if (if0.quotient !== 24'h001200) begin miscompares++; $display("FAIL disturb_quot: got %h want 001200", if0.quotient); end

    @(negedge clk);
    if0.start = 1'b1; if0.dividend = 16'd270; if0.divisor = 8'd14;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (if0.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", if0.busy); end
    vectors++; if (if0.ack !== 1'b0) begin miscompares++; $display("FAIL midreset_ack: got %b want 0", if0.ack); end
    vectors++; if (if0.quotient !== 24'h0) begin miscompares++; $display("FAIL midreset_quot: got %h want 000000", if0.quotient); end
    @(negedge clk);
    reset = 1'b0;
    do_op(1'b0, 16'd90, 8'd5, e, bn, h, t);
    vectors++; if (if0.quotient !== 24'h001200) begin miscompares++; $display("FAIL postreset_quot: got %h want 001200", if0.quotient); end
    vectors++; if (e != N0 + 2) begin miscompares++; $display("FAIL postreset_latency: got %0d want %0d", e, N0 + 2); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] av [3] = '{16'd90, 16'd270, 16'd3};
    logic [7:0]  bv [3] = '{8'd5, 8'd14, 8'd116};
    logic [23:0] qv [3] = '{24'h001200, 24'h001349, 24'h000006};
    int k, low_n;
    bit check_hold;
    @(negedge clk);
    if0.start = 1'b1; if0.dividend = av[0]; if0.divisor = bv[0];
    k = 0; low_n = 0; check_hold = 1'b0;
    for (int i = 0; i < 300 && k < 3; i++) begin
      @(posedge clk); #1;
      if (check_hold) begin
        check_hold = 1'b0;
        vectors++;
        if (if0.quotient !== qv[k-1]) begin miscompares++; $display("FAIL b2b%0d_hold: got %h want %h", k - 1, if0.quotient, qv[k-1]); end
      end
      if (if0.ack) begin
        vectors++;
        if (if0.quotient !== qv[k]) begin miscompares++; $display("FAIL b2b%0d_quot: got %h want %h", k, if0.quotient, qv[k]); end
        vectors++;
        if (low_n != N0 + 1) begin miscompares++; $display("FAIL b2b%0d_ack_gap: got %0d want %0d", k, low_n, N0 + 1); end
        k++;
        low_n = 0;
        if (k < 3) begin
          if0.dividend = av[k]; if0.divisor = bv[k];
          check_hold = 1'b1;
        end else begin
          if0.start = 1'b0;
        end
      end else begin
        low_n++;
      end
    end
    vectors++; if (k != 3) begin miscompares++; $display("FAIL b2b_timeout: got %0d results want 3", k); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (if0.ack !== 1'b1) begin miscompares++; $display("FAIL b2b_done_ack: got %b want 1", if0.ack); end
    vectors++; if (if0.quotient !== qv[2]) begin miscompares++; $display("FAIL b2b_done_hold: got %h want %h", if0.quotient, qv[2]); end
  endtask

  task automatic test_random();
    int e, bn; bit h, t, sel;
    logic [15:0] a;
    logic [7:0]  b;
    logic [23:0] exp_q, got_q;
    int exp_e;
    for (int n = 0; n < 40; n++) begin
      sel = n[0];
      a   = 16'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (n == 2) b = 8'd1;
      if (n == 4) begin a = 16'hFFFF; b = 8'd255; end
      do_op(sel, a, b, e, bn, h, t);
      exp_q = ref_q(sel ? 1 : 0, a, b);
      got_q = sel ? if1.quotient : if0.quotient;
      exp_e = (b == 8'd0) ? 1 : (sel ? N1 + 2 : N0 + 2);
      vectors++;
      if (got_q !== exp_q) begin miscompares++; $display("FAIL rand%0d_quot r=%0d %0d/%0d: got %h want %h", n, sel, a, b, got_q, exp_q); end
      vectors++;
      if ((sel ? if1.dz : if0.dz) !== (b == 8'd0)) begin miscompares++; $display("FAIL rand%0d_dz: got %b want %b", n, sel ? if1.dz : if0.dz, b == 8'd0); end
      vectors++;
      if (e != exp_e) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want %0d", n, e, exp_e); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_disturb();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
